// File: rtl/cache_mem_pkg.sv
// Shared definitions between the cache and its backing-memory controller.
// Latency: none (types and constants only).
// Backpressure: none.
package cache_mem_pkg;

  localparam int DEF_ADDRESS_SPACE = 12;
  localparam int DEF_DATA_SIZE     = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_WAIT = 3'd1,
    WR_WAIT = 3'd2,
    RD_ACK  = 3'd3,
    WR_ACK  = 3'd4,
    RELEASE = 3'd5
  } ctrl_state_t;

endpackage

// File: rtl/cache_ram_controller_if.sv
// Cache <-> backing-memory request bus (level requests, pulsed acks).
// Latency: none (wiring only).
// Backpressure: requests are held by the cache until the matching ack is seen.
interface cache_ram_controller_if
  import cache_mem_pkg::*;
#(
  parameter int ADDRESS_SPACE = DEF_ADDRESS_SPACE,
  parameter int DATA_SIZE     = DEF_DATA_SIZE
);

  logic                     fetch;
  logic                     flush;
  logic [ADDRESS_SPACE-1:0] addra;
  logic [DATA_SIZE-1:0]     dina;
  logic [DATA_SIZE-1:0]     douta;
  logic                     fetch_ack;
  logic                     flush_ack;
  logic                     busy;

  // cache side
  modport master (
    output fetch, flush, addra, dina,
    input  douta, fetch_ack, flush_ack, busy
  );

  // memory-controller side
  modport slave (
    input  fetch, flush, addra, dina,
    output douta, fetch_ack, flush_ack, busy
  );

endinterface

// File: rtl/backing_ram_array.sv
// Single-port synchronous RAM: one write port, registered read output.
// Latency: write commits on the enabled edge; read data appears one edge after re.
// Backpressure: none; always ready. Output register holds between reads.
module backing_ram_array
  import cache_mem_pkg::*;
#(
  parameter int ADDRESS_SPACE = DEF_ADDRESS_SPACE,
  parameter int DATA_SIZE     = DEF_DATA_SIZE
) (
  input  logic                     clka,
  input  logic                     rsta,
  input  logic                     we,
  input  logic                     re,
  input  logic [ADDRESS_SPACE-1:0] addr,
  input  logic [DATA_SIZE-1:0]     din,
  output logic [DATA_SIZE-1:0]     dout
);

  logic [DATA_SIZE-1:0] mem [0:(1<<ADDRESS_SPACE)-1];

  // Storage write; contents are deliberately never reset.
  always_ff @(posedge clka) begin
    if (we) mem[addr] <= din;
  end

  // Registered read port; only updates on an explicit read so it holds the last result.
  always_ff @(posedge clka) begin
    if (rsta)    dout <= '0;
    else if (re) dout <= mem[addr];
  end

endmodule

// File: rtl/cache_ram_controller.sv
// Backing-memory controller: services one fetch or flush at a time with fixed latency.
// Latency: ack pulse starts READ_LATENCY / WRITE_LATENCY edges after acceptance.
// Backpressure: busy outside IDLE; a request must drop before the next is accepted.
module cache_ram_controller
  import cache_mem_pkg::*;
#(
  parameter int ADDRESS_SPACE = DEF_ADDRESS_SPACE,
  parameter int DATA_SIZE     = DEF_DATA_SIZE,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                   clka,
  input  logic                   rsta,
  cache_ram_controller_if.slave  bus
);

  localparam logic [3:0] RD_LOAD = 4'(READ_LATENCY - 1);
  localparam logic [3:0] WR_LOAD = 4'(WRITE_LATENCY - 1);

  ctrl_state_t              state, state_nxt;
  logic [3:0]               cnt, cnt_nxt;
  logic [ADDRESS_SPACE-1:0] addr_q, addr_nxt;
  logic [DATA_SIZE-1:0]     data_q, data_nxt;
  logic                     serv_wr, serv_wr_nxt;   // which request level RELEASE waits on
  logic                     ram_we, ram_re;
  logic [DATA_SIZE-1:0]     ram_q;

  // State, latency counter and latched request registers.
  always_ff @(posedge clka) begin
    if (rsta) begin
      state   <= IDLE;
      cnt     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      serv_wr <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      addr_q  <= addr_nxt;
      data_q  <= data_nxt;
      serv_wr <= serv_wr_nxt;
    end
  end

  // Next-state logic; RAM access is issued on the last wait cycle so it lands on ACK entry.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    addr_nxt    = addr_q;
    data_nxt    = data_q;
    serv_wr_nxt = serv_wr;
    ram_we      = 1'b0;
    ram_re      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.flush) begin
          addr_nxt    = bus.addra;
          data_nxt    = bus.dina;
          cnt_nxt     = WR_LOAD;
          serv_wr_nxt = 1'b1;
          state_nxt   = WR_WAIT;
        end else if (bus.fetch) begin
          addr_nxt    = bus.addra;
          cnt_nxt     = RD_LOAD;
          serv_wr_nxt = 1'b0;
          state_nxt   = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (cnt == 4'd0) begin
          ram_re    = 1'b1;
          state_nxt = RD_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      WR_WAIT: begin
        if (cnt == 4'd0) begin
          ram_we    = 1'b1;
          state_nxt = WR_ACK;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RD_ACK, WR_ACK: state_nxt = RELEASE;
      RELEASE: begin
        if (serv_wr ? !bus.flush : !bus.fetch) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates the RAM strobes so an interrupted flush never commits.
  backing_ram_array #(
    .ADDRESS_SPACE (ADDRESS_SPACE),
    .DATA_SIZE     (DATA_SIZE)
  ) u_ram (
    .clka (clka),
    .rsta (rsta),
    .we   (ram_we & ~rsta),
    .re   (ram_re & ~rsta),
    .addr (addr_q),
    .din  (data_q),
    .dout (ram_q)
  );

  assign bus.douta     = ram_q;
  assign bus.fetch_ack = (state == RD_ACK);
  assign bus.flush_ack = (state == WR_ACK);
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_cache_ram_controller.sv
// Self-checking bench: default-latency and extreme-latency controllers vs. an array model.
// Latency: expected ack spacing is taken directly from each instance's parameters.
// Backpressure: requests are held by the bench until ack, then dropped.
module tb_cache_ram_controller;

  logic clka;
  logic rsta;
  logic sel;
  int   checks;
  int   errors;

  logic [31:0] model [logic [12:0]];
  logic [11:0] waddrs [$];

  cache_ram_controller_if #(.ADDRESS_SPACE(12), .DATA_SIZE(32)) a_if ();
  cache_ram_controller_if #(.ADDRESS_SPACE(12), .DATA_SIZE(32)) b_if ();

  cache_ram_controller #(
    .ADDRESS_SPACE(12), .DATA_SIZE(32), .READ_LATENCY(4), .WRITE_LATENCY(4)
  ) dut_a (.clka(clka), .rsta(rsta), .bus(a_if));

  cache_ram_controller #(
    .ADDRESS_SPACE(12), .DATA_SIZE(32), .READ_LATENCY(1), .WRITE_LATENCY(15)
  ) dut_b (.clka(clka), .rsta(rsta), .bus(b_if));

  wire        o_fack = sel ? b_if.fetch_ack : a_if.fetch_ack;
  wire        o_wack = sel ? b_if.flush_ack : a_if.flush_ack;
  wire        o_busy = sel ? b_if.busy      : a_if.busy;
  wire [31:0] o_dout = sel ? b_if.douta     : a_if.douta;

  initial begin
    clka = 1'b0;
    forever #5 clka = ~clka;
  end

  task automatic set_req(input bit s, input bit is_wr, input logic v);
    if (s) begin
      if (is_wr) b_if.flush = v; else b_if.fetch = v;
    end else begin
      if (is_wr) a_if.flush = v; else a_if.fetch = v;
    end
  endtask

  task automatic set_bus(input bit s, input logic [11:0] a, input logic [31:0] d);
    if (s) begin b_if.addra = a; b_if.dina = d; end
    else   begin a_if.addra = a; a_if.dina = d; end
  endtask

  // One complete request: drive, measure ack latency, check data, hold, release.
  task automatic xact(input bit s, input bit is_wr, input bit both,
                      input logic [11:0] a, input logic [31:0] d,
                      input int hold, input bit toggle, input int exp_lat);
    int          lat;
    int          extra;
    bit          got;
    logic [31:0] exp_d;
    @(negedge clka);
    sel  = s;
    rsta = 1'b0;
    set_bus(s, a, d);
    set_req(s, is_wr, 1'b1);
    if (both) set_req(s, !is_wr, 1'b1);
    @(posedge clka); #1;
    checks++;
    if (o_busy !== 1'b1) begin
      errors++; $display("FAIL accept_busy addr=%h got=%b want=1", a, o_busy);
    end
    lat = 0; got = 0;
    while (!got && lat < 40) begin
      if (toggle) set_bus(s, 12'($urandom), $urandom);
      @(posedge clka); #1;
      lat++;
      if (is_wr ? o_wack : o_fack) got = 1;
      else if (is_wr ? o_fack : o_wack) begin
        checks++; errors++;
        $display("FAIL wrong_ack addr=%h cycle=%0d", a, lat);
      end
    end
    checks++;
    if (!got || lat != exp_lat) begin
      errors++; $display("FAIL ack_latency addr=%h got=%0d want=%0d seen=%0d", a, lat, exp_lat, got);
    end
    exp_d = 32'h0;
    if (!is_wr) begin
      exp_d = model[{s, a}];
      checks++;
      if (o_dout !== exp_d) begin
        errors++; $display("FAIL read_data addr=%h got=%h want=%h", a, o_dout, exp_d);
      end
    end else begin
      if (!model.exists({s, a})) waddrs.push_back(a);
      model[{s, a}] = d;
    end
    extra = 0;
    for (int i = 0; i < hold + 1; i++) begin
      @(posedge clka); #1;
      if (o_fack || o_wack) extra++;
      checks++;
      if (o_busy !== 1'b1) begin
        errors++; $display("FAIL hold_busy addr=%h cycle=%0d got=%b want=1", a, i, o_busy);
      end
    end
    checks++;
    if (extra != 0) begin
      errors++; $display("FAIL ack_pulse addr=%h extra_acks=%0d want=0", a, extra);
    end
    if (!is_wr) begin
      checks++;
      if (o_dout !== exp_d) begin
        errors++; $display("FAIL dout_hold addr=%h got=%h want=%h", a, o_dout, exp_d);
      end
    end
    @(negedge clka);
    set_req(s, is_wr, 1'b0);
    @(posedge clka); #1;
    checks++;
    if (o_busy !== 1'b0) begin
      errors++; $display("FAIL release_idle addr=%h got=%b want=0", a, o_busy);
    end
  endtask

  task automatic test_reset();
    rsta = 1'b1;
    repeat (3) @(posedge clka);
    #1;
    checks++;
    if (a_if.busy !== 1'b0 || a_if.fetch_ack !== 1'b0 || a_if.flush_ack !== 1'b0 || a_if.douta !== 32'h0) begin
      errors++;
      $display("FAIL reset_a busy=%b fack=%b wack=%b dout=%h want 0/0/0/0",
               a_if.busy, a_if.fetch_ack, a_if.flush_ack, a_if.douta);
    end
    checks++;
    if (b_if.busy !== 1'b0 || b_if.fetch_ack !== 1'b0 || b_if.flush_ack !== 1'b0 || b_if.douta !== 32'h0) begin
      errors++;
      $display("FAIL reset_b busy=%b fack=%b wack=%b dout=%h want 0/0/0/0",
               b_if.busy, b_if.fetch_ack, b_if.flush_ack, b_if.douta);
    end
  endtask

  // First request goes in on the very negedge that releases reset.
  task automatic test_basic();
    xact(0, 1, 0, 12'h005, 32'hDEADBEEF, 0, 0, 4);
    xact(0, 0, 0, 12'h005, 32'h0, 0, 0, 4);
  endtask

  task automatic test_simultaneous();
    xact(0, 1, 1, 12'h3FF, 32'h12345678, 0, 0, 4);
    xact(0, 0, 0, 12'h3FF, 32'h0, 0, 0, 4);
  endtask

  task automatic test_hold();
    xact(0, 0, 0, 12'h005, 32'h0, 3, 0, 4);
  endtask

  task automatic test_reset_mid_flush();
    logic [31:0] prior;
    int          bad;
    prior = $urandom;
    xact(0, 1, 0, 12'h010, prior, 0, 0, 4);
    @(negedge clka);
    sel = 0;
    set_bus(0, 12'h010, 32'hCAFEF00D);
    set_req(0, 1, 1'b1);
    repeat (3) @(posedge clka);
    @(negedge clka);
    rsta = 1'b1;
    bad = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clka); #1;
      if (a_if.flush_ack || a_if.busy || a_if.douta !== 32'h0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL reset_abort bad_cycles=%0d want=0", bad);
    end
    @(negedge clka);
    set_req(0, 1, 1'b0);
    xact(0, 0, 0, 12'h010, 32'h0, 0, 0, 4);
  endtask

  task automatic test_latency_extremes();
    xact(1, 1, 0, 12'h000, 32'hA0A0_0000, 0, 0, 15);
    xact(1, 1, 0, 12'hFFF, 32'h5F5F_0FFF, 0, 0, 15);
    xact(1, 0, 0, 12'h000, 32'h0, 0, 0, 1);
    xact(1, 0, 0, 12'hFFF, 32'h0, 1, 0, 1);
  endtask

  task automatic test_toggle_during_wait();
    xact(0, 1, 0, 12'h123, 32'hA5A5_0001, 0, 1, 4);
    xact(0, 0, 0, 12'h123, 32'h0, 0, 0, 4);
  endtask

  task automatic test_random();
    logic [11:0] a;
    for (int n = 0; n < 30; n++) begin
      if (waddrs.size() == 0 || ($urandom % 2) == 0) begin
        a = 12'($urandom);
        xact(0, 1, 0, a, $urandom, int'($urandom_range(0, 2)), 1'($urandom % 2), 4);
      end else begin
        a = waddrs[$urandom_range(0, waddrs.size() - 1)];
        xact(0, 0, 0, a, 32'h0, int'($urandom_range(0, 2)), 0, 4);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel    = 1'b0;
    rsta   = 1'b1;
    a_if.fetch = 1'b0; a_if.flush = 1'b0; a_if.addra = '0; a_if.dina = '0;
    b_if.fetch = 1'b0; b_if.flush = 1'b0; b_if.addra = '0; b_if.dina = '0;
    test_reset();
    test_basic();
    test_simultaneous();
    test_hold();
    test_reset_mid_flush();
    test_latency_extremes();
    test_toggle_during_wait();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_ram_controller.md
CACHE_RAM_CONTROLLER -- requirements
Module: cache_ram_controller

Interface
REQ-001 Parameter ADDRESS_SPACE, default 12: backing-memory address width; memory depth 2**ADDRESS_SPACE words.
REQ-002 Parameter DATA_SIZE, default 32: word width.
REQ-003 Parameter READ_LATENCY, default 4, legal range 1..15: cycles from fetch acceptance to fetch_ack.
REQ-004 Parameter WRITE_LATENCY, default 4, legal range 1..15: cycles from flush acceptance to flush_ack.
REQ-005 clka  input  1  clock; all logic on its rising edge.
REQ-006 rsta  input  1  reset; synchronous, active-high.
REQ-007 fetch  input  1  read request from cache; level, held until fetch_ack is seen.
REQ-008 flush  input  1  write-through request from cache; level, held until flush_ack is seen.
REQ-009 addra  input  ADDRESS_SPACE  full word address for the request.
REQ-010 dina  input  DATA_SIZE  write data for flush.
REQ-011 douta  output  DATA_SIZE  read data to cache; valid while fetch_ack=1.
REQ-012 fetch_ack  output  1  one-cycle pulse; read data on douta.
REQ-013 flush_ack  output  1  one-cycle pulse; write committed.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, RD_WAIT, WR_WAIT, RD_ACK, WR_ACK, RELEASE.
REQ-016 In IDLE with flush=1, it SHALL latch addra/dina, load the counter with WRITE_LATENCY-1, and go to WR_WAIT.
REQ-017 In IDLE with fetch=1 and flush=0, it SHALL latch addra, load the counter with READ_LATENCY-1, and go to RD_WAIT; simultaneous fetch and flush: flush wins, and fetch stays pending.
REQ-018 In RD_WAIT/WR_WAIT, the counter SHALL decrement each cycle; at count 0, the FSM SHALL go to RD_ACK/WR_ACK on the next edge.
REQ-019 First ack-high cycle SHALL begin exactly READ_LATENCY/WRITE_LATENCY edges after the acceptance edge.
REQ-020 On entering RD_ACK, douta SHALL load mem[latched address]; douta SHALL hold that value until the next RD_ACK entry.
REQ-021 On entering WR_ACK, mem[latched address] SHALL be written with the latched data; no write SHALL occur at any other time.
REQ-022 fetch_ack SHALL be 1 only in RD_ACK and flush_ack only in WR_ACK, each exactly one cycle.
REQ-023 From RD_ACK/WR_ACK, the FSM SHALL go to RELEASE, and stay until the serviced request is low; it then SHALL go to IDLE, so one request level is never serviced twice.
REQ-024 Changes to addra/dina/request after acceptance SHALL be ignored until IDLE.
REQ-025 A read of an address flushed earlier SHALL return the flushed data, so read-after-write is coherent.
REQ-026 Address SHALL use all ADDRESS_SPACE bits, with no aliasing; max address 2**ADDRESS_SPACE-1 is valid.

Reset
REQ-027 While rsta=1: FSM to IDLE; fetch_ack=0, flush_ack=0, busy=0, douta=0, counter=0.
REQ-028 rsta SHALL override any state; a flush reset before WR_ACK SHALL leave memory unchanged.
REQ-029 Memory array contents SHALL not be reset.
REQ-030 The first request SHALL be accepted on the first edge with rsta=0.

Structure
REQ-031 A shared package cache_mem_pkg SHALL hold the state encodings and the default ADDRESS_SPACE/DATA_SIZE values, shared with the cache.
REQ-032 The storage SHALL be one sub-module, backing_ram_array: a single-port synchronous RAM with one write port, registered read, and parameters ADDRESS_SPACE/DATA_SIZE.
REQ-033 The latency counter SHALL be 4 bits, inline in the controller.

Verification
REQ-034 Reset, then flush addr 0x005 data 0xDEADBEEF -> flush_ack pulse 4 cycles after acceptance; then fetch 0x005 -> fetch_ack after 4 cycles, douta=0xDEADBEEF.
REQ-035 fetch and flush both high in IDLE, addr 0x3FF, data 0x12345678 -> flush serviced first; then fetch returns 0x12345678.
REQ-036 Hold fetch high 3 extra cycles after fetch_ack -> exactly one fetch_ack; busy=1 until fetch drops.
REQ-037 rsta asserted 2 cycles into a flush of 0xCAFEF00D to 0x010 -> no flush_ack; later fetch of 0x010 returns the prior contents.
REQ-038 READ_LATENCY=1, WRITE_LATENCY=15 -> ack spacing 1 and 15 cycles exactly; flush at 0x000 and fetch at 0xFFF show no aliasing.
REQ-039 addra/dina toggled every cycle during WR_WAIT -> the latched address/data are the ones committed.
